mod_counter_bank: RTL

//  Bank of N_CH independent modulo counters, each running up or down to a

---
 rtl/ctr_pkg.sv | 17 +
 rtl/counter_chan.sv | 56 +++++
 rtl/mod_counter_bank.sv | 52 +++++
 3 files changed

// File: rtl/ctr_pkg.sv
// Shared constants and helpers for the modulo counter bank.
// Direction encodings, legal parameter ranges and packed-bus slice offsets.
package ctr_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int unsigned W_MIN    = 2;
  localparam int unsigned W_MAX    = 16;
  localparam int unsigned N_CH_MAX = 8;

  // Low bit of channel idx inside a packed N_CH*W bus.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/counter_chan.sv
// One modulo counter channel, up or down to a programmable limit; count/tc registered, 1 clk after step.
// No backpressure: load and step are accepted every cycle, priority reset > load > step > hold.
module counter_chan
  import ctr_pkg::*;
#(
  parameter int unsigned W   = 4,
  parameter logic        DIR = DIR_UP
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         tc_o,
  output logic         term_step_o
);

  logic [W-1:0] count_q, count_d;
  logic         tc_q, tc_d;
  logic         at_term;

  // Up uses >= so a limit lowered below the current count wraps on the next step.
  assign at_term     = (DIR == DIR_DOWN) ? (count_q == '0) : (count_q >= limit_i);
  assign term_step_o = step_i & ~load_i & at_term;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load_i) begin
      count_d = load_val_i;
    end else if (step_i) begin
      tc_d = at_term;
      if (DIR == DIR_DOWN) begin
        count_d = at_term ? limit_i : (count_q - 1'b1);
      end else begin
        count_d = at_term ? '0 : (count_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= (DIR == DIR_DOWN) ? limit_i : '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;

endmodule

// File: rtl/mod_counter_bank.sv
// Bank of N_CH modulo counters with optional cascade chaining; outputs registered, 1 clk latency.
// No backpressure: every channel accepts enable/load on every cycle; this level is wiring only.
module mod_counter_bank
  import ctr_pkg::*;
#(
  parameter int unsigned     N_CH      = 2,
  parameter int unsigned     W         = 4,
  parameter logic [N_CH-1:0] DOWN_MASK = 2'b10,
  parameter bit              CASCADE   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   en_i,
  input  logic [N_CH-1:0]   load_i,
  input  logic [N_CH*W-1:0] load_val,
  input  logic [N_CH*W-1:0] limit_i,
  output logic [N_CH*W-1:0] count_o,
  output logic [N_CH-1:0]   tc_o
);

  if (W < W_MIN || W > W_MAX || N_CH < 1 || N_CH > N_CH_MAX) begin : g_bad_param
    $error("mod_counter_bank: unsupported N_CH/W");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic step_en;
    logic term_step;

    // Per-stage scalars keep the carry ripple free of self-dependent vectors.
    if (CASCADE && i > 0) begin : g_casc
      assign step_en = en_i[i] & g_ch[i-1].term_step;
    end else begin : g_base
      assign step_en = en_i[i];
    end

    counter_chan #(
      .W   (W),
      .DIR (DOWN_MASK[i])
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .step_i      (step_en),
      .load_i      (load_i[i]),
      .load_val_i  (load_val[slice_lo(i, W) +: W]),
      .limit_i     (limit_i[slice_lo(i, W) +: W]),
      .count_o     (count_o[slice_lo(i, W) +: W]),
      .tc_o        (tc_o[i]),
      .term_step_o (term_step)
    );
  end

endmodule
